// File: rtl/axi4_echo_pkg.sv
// Shared widths and payload packing helpers for the echo-yanker channel pair.
// Functions give AX/R/B payloads one canonical bit ordering across the fabric.
package axi4_echo_pkg;

  localparam int ID_W_DEF   = 1;
  localparam int ECHO_W_DEF = 7;
  localparam int DEPTH_DEF  = 4;
  localparam int REQ_W_AX   = 52;
  localparam int RSP_W_R    = 66;
  localparam int RSP_W_B    = 2;

  function automatic logic [REQ_W_AX-1:0] pack_ax(
    input logic [31:0] addr,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst,
    input logic [3:0]  cache,
    input logic [2:0]  prot
  );
    return {addr, len, size, burst, cache, prot};
  endfunction

  function automatic logic [RSP_W_R-1:0] pack_r(
    input logic [63:0] data,
    input logic [1:0]  resp
  );
    return {data, resp};
  endfunction

  function automatic logic [RSP_W_B-1:0] pack_b(input logic [1:0] resp);
    return resp;
  endfunction

endpackage

// File: rtl/axi4_echo_fifo.sv
// One per-ID echo queue: small circular buffer with a combinational head so
// the response path can attach the echo in the same cycle it arrives.
module axi4_echo_fifo
  import axi4_echo_pkg::*;
#(
  parameter int ECHO_W = ECHO_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              push,
  input  logic [ECHO_W-1:0] push_data,
  input  logic              pop,
  output logic [ECHO_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ECHO_W-1:0] mem_reg [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     cnt_reg;
  logic [CW-1:0]     cnt_next;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (cnt_reg == CW'(DEPTH));
  assign empty   = (cnt_reg == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_reg[rd_ptr_reg];

  always_comb begin
    cnt_next = cnt_reg;
    case ({push_ok, pop_ok})
      2'b10:   cnt_next = cnt_reg + CW'(1);
      2'b01:   cnt_next = cnt_reg - CW'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      cnt_reg <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/axi4_echo_yanker.sv
// Strips the echo ID field from requests into per-ID queues and re-attaches
// it to the matching responses; one instance per direction (AR/R or AW/B).
module axi4_echo_yanker
  import axi4_echo_pkg::*;
#(
  parameter int ID_W   = ID_W_DEF,
  parameter int ECHO_W = ECHO_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int REQ_W  = REQ_W_AX,
  parameter int RSP_W  = RSP_W_R
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              req_in_valid,
  output logic              req_in_ready,
  input  logic [ID_W-1:0]   req_in_id,
  input  logic [ECHO_W-1:0] req_in_echo,
  input  logic [REQ_W-1:0]  req_in_payload,
  output logic              req_out_valid,
  input  logic              req_out_ready,
  output logic [ID_W-1:0]   req_out_id,
  output logic [REQ_W-1:0]  req_out_payload,
  input  logic              rsp_in_valid,
  output logic              rsp_in_ready,
  input  logic [ID_W-1:0]   rsp_in_id,
  input  logic              rsp_in_last,
  input  logic [RSP_W-1:0]  rsp_in_payload,
  output logic              rsp_out_valid,
  input  logic              rsp_out_ready,
  output logic [ID_W-1:0]   rsp_out_id,
  output logic [ECHO_W-1:0] rsp_out_echo,
  output logic              rsp_out_last,
  output logic [RSP_W-1:0]  rsp_out_payload,
  output logic              err_unexpected
);

  localparam int NQ = 2 ** ID_W;

  logic [NQ-1:0]     full_vec;
  logic [NQ-1:0]     empty_vec;
  logic [NQ-1:0]     push_vec;
  logic [NQ-1:0]     pop_vec;
  logic [ECHO_W-1:0] head_arr [NQ];
  logic              req_full;
  logic              req_fire;
  logic              rsp_fire;
  logic              rsp_empty;
  logic              err_reg;

  // Request side: a full queue stalls only requests carrying its own ID.
  assign req_full        = full_vec[req_in_id];
  assign req_out_valid   = rstnn & req_in_valid & ~req_full;
  assign req_in_ready    = rstnn & req_out_ready & ~req_full;
  assign req_out_id      = req_in_id;
  assign req_out_payload = req_in_payload;
  assign req_fire        = req_in_valid & req_in_ready;

  assign rsp_out_valid   = rsp_in_valid;
  assign rsp_in_ready    = rsp_out_ready;
  assign rsp_out_id      = rsp_in_id;
  assign rsp_out_last    = rsp_in_last;
  assign rsp_out_payload = rsp_in_payload;
  assign rsp_fire        = rsp_in_valid & rsp_out_ready;
  assign rsp_empty       = empty_vec[rsp_in_id];
  assign rsp_out_echo    = rsp_empty ? '0 : head_arr[rsp_in_id];

  genvar gi;
  generate
    for (gi = 0; gi < NQ; gi++) begin : g_q
      assign push_vec[gi] = req_fire && (req_in_id == ID_W'(gi));
      // Non-last beats of a burst keep the head; only the final beat retires it.
      assign pop_vec[gi]  = rsp_fire && rsp_in_last && (rsp_in_id == ID_W'(gi));

      axi4_echo_fifo #(
        .ECHO_W (ECHO_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rstnn     (rstnn),
        .push      (push_vec[gi]),
        .push_data (req_in_echo),
        .pop       (pop_vec[gi]),
        .head      (head_arr[gi]),
        .full      (full_vec[gi]),
        .empty     (empty_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      err_reg <= 1'b0;
    end else if (rsp_fire && rsp_empty) begin
      err_reg <= 1'b1;
    end
  end

  assign err_unexpected = err_reg;

endmodule

// File: tb/tb_axi4_echo_yanker.sv
// Directed vector table plus randomized traffic checked against a queue model.
module tb_axi4_echo_yanker;
  import axi4_echo_pkg::*;

  localparam int ID_W   = 1;
  localparam int ECHO_W = 7;
  localparam int DEPTH  = 4;
  localparam int REQ_W  = REQ_W_AX;
  localparam int RSP_W  = RSP_W_R;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstnn;
  logic              req_in_valid, req_in_ready;
  logic [ID_W-1:0]   req_in_id;
  logic [ECHO_W-1:0] req_in_echo;
  logic [REQ_W-1:0]  req_in_payload;
  logic              req_out_valid, req_out_ready;
  logic [ID_W-1:0]   req_out_id;
  logic [REQ_W-1:0]  req_out_payload;
  logic              rsp_in_valid, rsp_in_ready;
  logic [ID_W-1:0]   rsp_in_id;
  logic              rsp_in_last;
  logic [RSP_W-1:0]  rsp_in_payload;
  logic              rsp_out_valid, rsp_out_ready;
  logic [ID_W-1:0]   rsp_out_id;
  logic [ECHO_W-1:0] rsp_out_echo;
  logic              rsp_out_last;
  logic [RSP_W-1:0]  rsp_out_payload;
  logic              err_unexpected;

  axi4_echo_yanker #(
    .ID_W(ID_W), .ECHO_W(ECHO_W), .DEPTH(DEPTH), .REQ_W(REQ_W), .RSP_W(RSP_W)
  ) dut (
    .clk(clk), .rstnn(rstnn),
    .req_in_valid(req_in_valid), .req_in_ready(req_in_ready), .req_in_id(req_in_id),
    .req_in_echo(req_in_echo), .req_in_payload(req_in_payload),
    .req_out_valid(req_out_valid), .req_out_ready(req_out_ready),
    .req_out_id(req_out_id), .req_out_payload(req_out_payload),
    .rsp_in_valid(rsp_in_valid), .rsp_in_ready(rsp_in_ready), .rsp_in_id(rsp_in_id),
    .rsp_in_last(rsp_in_last), .rsp_in_payload(rsp_in_payload),
    .rsp_out_valid(rsp_out_valid), .rsp_out_ready(rsp_out_ready),
    .rsp_out_id(rsp_out_id), .rsp_out_echo(rsp_out_echo), .rsp_out_last(rsp_out_last),
    .rsp_out_payload(rsp_out_payload), .err_unexpected(err_unexpected)
  );

  typedef struct {
    string      name;
    logic       rstn, rq_v, rq_id; logic [6:0] rq_echo; logic rq_rdy;
    logic       rs_v, rs_id, rs_last, rs_rdy;
    logic       x_rdy, x_val; logic [6:0] x_echo; logic x_err;
  } vec_t;

  vec_t tv[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  // Reference model: one FIFO of echoes per ID plus the sticky error flag.
  int   mq0[$];
  int   mq1[$];
  logic m_err = 1'b0;

  function automatic vec_t mk(string n, logic rstn, logic rqv, logic rqid, logic [6:0] e,
                              logic rqr, logic rsv, logic rsid, logic l, logic rsr,
                              logic xr, logic xv, logic [6:0] xe, logic xerr);
    vec_t v;
    v.name = n; v.rstn = rstn; v.rq_v = rqv; v.rq_id = rqid; v.rq_echo = e; v.rq_rdy = rqr;
    v.rs_v = rsv; v.rs_id = rsid; v.rs_last = l; v.rs_rdy = rsr;
    v.x_rdy = xr; v.x_val = xv; v.x_echo = xe; v.x_err = xerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int qsize(input logic id);
    return id ? mq1.size() : mq0.size();
  endfunction

  function automatic int qhead(input logic id);
    if (qsize(id) == 0) return 0;
    return id ? mq1[0] : mq0[0];
  endfunction

  task automatic model_update(input vec_t v);
    logic rq_fire, rs_fire, was_empty;
    rq_fire   = v.rstn && v.rq_v && v.rq_rdy && (qsize(v.rq_id) < DEPTH);
    rs_fire   = v.rs_v && v.rs_rdy;
    was_empty = (qsize(v.rs_id) == 0);
    if (!v.rstn) begin
      mq0.delete(); mq1.delete(); m_err = 1'b0;
    end else begin
      if (rs_fire && was_empty) m_err = 1'b1;
      if (rs_fire && v.rs_last && !was_empty) begin
        if (v.rs_id) void'(mq1.pop_front()); else void'(mq0.pop_front());
      end
      if (rq_fire) begin
        if (v.rq_id) mq1.push_back(int'(v.rq_echo)); else mq0.push_back(int'(v.rq_echo));
      end
    end
  endtask

  // Drive one cycle, check mid-cycle, then advance the model past the edge.
  task automatic run_cycle(input vec_t v, input bit use_model);
    logic x_rdy, x_val, x_err; logic [6:0] x_echo; logic full;
    rstnn = v.rstn; req_in_valid = v.rq_v; req_in_id = v.rq_id; req_in_echo = v.rq_echo;
    req_out_ready = v.rq_rdy; rsp_in_valid = v.rs_v; rsp_in_id = v.rs_id;
    rsp_in_last = v.rs_last; rsp_out_ready = v.rs_rdy;
    req_in_payload = pack_ax($urandom, 8'($urandom), 3'($urandom), 2'($urandom),
                             4'($urandom), 3'($urandom));
    rsp_in_payload = pack_r({$urandom, $urandom}, 2'($urandom));
    #3;
    if (use_model) begin
      full   = (qsize(v.rq_id) >= DEPTH);
      x_rdy  = v.rstn && v.rq_rdy && !full;
      x_val  = v.rstn && v.rq_v && !full;
      x_echo = 7'(qhead(v.rs_id));
      x_err  = m_err;
    end else begin
      x_rdy = v.x_rdy; x_val = v.x_val; x_echo = v.x_echo; x_err = v.x_err;
    end
    check({v.name, ".req_in_ready"}, 128'(req_in_ready), 128'(x_rdy));
    check({v.name, ".req_out_valid"}, 128'(req_out_valid), 128'(x_val));
    check({v.name, ".rsp_out_echo"}, 128'(rsp_out_echo), 128'(x_echo));
    check({v.name, ".err_unexpected"}, 128'(err_unexpected), 128'(x_err));
    check({v.name, ".req_pass"}, 128'({req_out_id, req_out_payload}),
          128'({req_in_id, req_in_payload}));
    check({v.name, ".rsp_pass"},
          128'({rsp_out_valid, rsp_in_ready, rsp_out_id, rsp_out_last, rsp_out_payload}),
          128'({rsp_in_valid, rsp_out_ready, rsp_in_id, rsp_in_last, rsp_in_payload}));
    $display("cycle %-14s rdy=%0b val=%0b echo=%02h err=%0b", v.name,
             req_in_ready, req_out_valid, rsp_out_echo, err_unexpected);
    @(posedge clk);
    model_update(v);
    #1;
  endtask

  initial begin
    vec_t v;
    rstnn = 1'b0; req_in_valid = 1'b0; req_in_id = '0; req_in_echo = '0; req_in_payload = '0;
    req_out_ready = 1'b0; rsp_in_valid = 1'b0; rsp_in_id = '0; rsp_in_last = 1'b0;
    rsp_in_payload = '0; rsp_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //            name            rstn rqv id echo   rdy rsv id lst rdy  xrdy xval xecho xerr
    tv.push_back(mk("rst_hold",      0, 1, 0, 7'h00, 1,  0, 0, 0, 1,   0, 0, 7'h00, 0));
    tv.push_back(mk("t1_ar0",        1, 1, 0, 7'h15, 1,  0, 0, 0, 1,   1, 1, 7'h00, 0));
    tv.push_back(mk("t1_ar1",        1, 1, 1, 7'h2A, 1,  0, 0, 0, 1,   1, 1, 7'h15, 0));
    tv.push_back(mk("t1_r1",         1, 0, 0, 7'h00, 1,  1, 1, 1, 1,   1, 0, 7'h2A, 0));
    tv.push_back(mk("t1_r0",         1, 0, 0, 7'h00, 1,  1, 0, 1, 1,   1, 0, 7'h15, 0));
    tv.push_back(mk("t1_q0_empty",   1, 0, 0, 7'h00, 1,  0, 0, 0, 1,   1, 0, 7'h00, 0));
    tv.push_back(mk("t1_q1_empty",   1, 0, 0, 7'h00, 1,  0, 1, 0, 1,   1, 0, 7'h00, 0));
    tv.push_back(mk("t1_no_ready",   1, 1, 0, 7'h7F, 0,  0, 0, 0, 1,   0, 1, 7'h00, 0));
    tv.push_back(mk("t2_fill1",      1, 1, 0, 7'h01, 1,  0, 0, 0, 1,   1, 1, 7'h00, 0));
    tv.push_back(mk("t2_fill2",      1, 1, 0, 7'h02, 1,  0, 0, 0, 1,   1, 1, 7'h01, 0));
    tv.push_back(mk("t2_fill3",      1, 1, 0, 7'h03, 1,  0, 0, 0, 1,   1, 1, 7'h01, 0));
    tv.push_back(mk("t2_fill4",      1, 1, 0, 7'h04, 1,  0, 0, 0, 1,   1, 1, 7'h01, 0));
    tv.push_back(mk("t2_full0",      1, 1, 0, 7'h05, 1,  0, 0, 0, 1,   0, 0, 7'h01, 0));
    tv.push_back(mk("t2_id1_ok",     1, 1, 1, 7'h40, 1,  0, 1, 0, 1,   1, 1, 7'h00, 0));
    tv.push_back(mk("t3_pop_stall",  1, 1, 0, 7'h05, 1,  1, 0, 1, 1,   0, 0, 7'h01, 0));
    tv.push_back(mk("t3_accept",     1, 1, 0, 7'h05, 1,  0, 0, 0, 1,   1, 1, 7'h02, 0));
    tv.push_back(mk("t3_full_again", 1, 1, 0, 7'h06, 1,  0, 0, 0, 1,   0, 0, 7'h02, 0));
    tv.push_back(mk("t4_drain2",     1, 0, 0, 7'h00, 1,  1, 0, 1, 1,   0, 0, 7'h02, 0));
    tv.push_back(mk("t4_drain3",     1, 0, 0, 7'h00, 1,  1, 0, 1, 1,   1, 0, 7'h03, 0));
    tv.push_back(mk("t4_drain4",     1, 0, 0, 7'h00, 1,  1, 0, 1, 1,   1, 0, 7'h04, 0));
    tv.push_back(mk("t4_pop_push",   1, 1, 0, 7'h33, 1,  1, 0, 1, 1,   1, 1, 7'h05, 0));
    tv.push_back(mk("t4_push",       1, 1, 0, 7'h34, 1,  0, 0, 0, 1,   1, 1, 7'h33, 0));
    tv.push_back(mk("t4_beat1",      1, 0, 0, 7'h00, 1,  1, 0, 0, 1,   1, 0, 7'h33, 0));
    tv.push_back(mk("t4_beat2",      1, 0, 0, 7'h00, 1,  1, 0, 0, 1,   1, 0, 7'h33, 0));
    tv.push_back(mk("t4_beat3",      1, 0, 0, 7'h00, 1,  1, 0, 0, 1,   1, 0, 7'h33, 0));
    tv.push_back(mk("t4_last",       1, 0, 0, 7'h00, 1,  1, 0, 1, 1,   1, 0, 7'h33, 0));
    tv.push_back(mk("t4_next",       1, 0, 0, 7'h00, 1,  1, 0, 1, 1,   1, 0, 7'h34, 0));
    tv.push_back(mk("t4_pop_id1",    1, 0, 0, 7'h00, 1,  1, 1, 1, 1,   1, 0, 7'h40, 0));
    tv.push_back(mk("t5_no_fire",    1, 0, 0, 7'h00, 1,  1, 1, 1, 0,   1, 0, 7'h00, 0));
    tv.push_back(mk("t5_unexp",      1, 0, 0, 7'h00, 1,  1, 1, 1, 1,   1, 0, 7'h00, 0));
    tv.push_back(mk("t5_err_set",    1, 0, 0, 7'h00, 1,  0, 1, 0, 1,   1, 0, 7'h00, 1));
    tv.push_back(mk("t5_err_hold",   1, 0, 0, 7'h00, 1,  0, 0, 0, 1,   1, 0, 7'h00, 1));
    tv.push_back(mk("t6_fill1",      1, 1, 0, 7'h11, 1,  0, 0, 0, 1,   1, 1, 7'h00, 1));
    tv.push_back(mk("t6_fill2",      1, 1, 0, 7'h12, 1,  0, 0, 0, 1,   1, 1, 7'h11, 1));
    tv.push_back(mk("t6_fill3",      1, 1, 0, 7'h13, 1,  0, 0, 0, 1,   1, 1, 7'h11, 1));
    tv.push_back(mk("t6_reset",      0, 1, 0, 7'h14, 1,  0, 0, 0, 1,   0, 0, 7'h11, 1));
    tv.push_back(mk("t6_after",      1, 0, 0, 7'h00, 1,  0, 0, 0, 1,   1, 0, 7'h00, 0));
    tv.push_back(mk("t6_r_empty",    1, 0, 0, 7'h00, 1,  1, 0, 1, 1,   1, 0, 7'h00, 0));
    tv.push_back(mk("t6_err",        1, 0, 0, 7'h00, 1,  0, 0, 0, 1,   1, 0, 7'h00, 1));

    foreach (tv[i]) run_cycle(tv[i], 1'b0);

    // Random traffic; responses mostly target non-empty queues.
    for (int n = 0; n < 2000; n++) begin
      v = mk("rand", 1, 0, 0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 7'h00, 0);
      v.rstn    = ($urandom_range(0, 99) != 0);
      v.rq_v    = ($urandom_range(0, 9) < 7);
      v.rq_id   = 1'($urandom);
      v.rq_echo = 7'($urandom);
      v.rq_rdy  = ($urandom_range(0, 9) < 8);
      v.rs_v    = ($urandom_range(0, 9) < 6);
      v.rs_id   = 1'($urandom);
      if ($urandom_range(0, 9) != 0 && qsize(v.rs_id) == 0) v.rs_id = ~v.rs_id;
      v.rs_last = 1'($urandom);
      v.rs_rdy  = ($urandom_range(0, 9) < 8);
      run_cycle(v, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
